// File: rtl/gray_pos_tracker_pkg.sv
// rtl/gray_pos_tracker_pkg.sv - shared state encoding and direction codes for the Gray position tracker
package gray_pos_tracker_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DN   = 2'b10;

endpackage

// File: rtl/gray2bin4.sv
// rtl/gray2bin4.sv - combinational 4-bit reflected Gray to binary decode
module gray2bin4 (
   input  logic [3:0] i_gray,
   output logic [3:0] o_bin
);

   // Each binary bit is the XOR of all Gray bits at or above it.
   assign o_bin[3] = i_gray[3];
   assign o_bin[2] = ^i_gray[3:2];
   assign o_bin[1] = ^i_gray[3:1];
   assign o_bin[0] = ^i_gray[3:0];

endmodule

// File: rtl/gray_pos_tracker.sv
// rtl/gray_pos_tracker.sv - tracks signed position from a 4-bit Gray sample stream
module gray_pos_tracker
   import gray_pos_tracker_pkg::*;
#(
   parameter int unsigned POS_W = 8,
   parameter int unsigned ERR_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_gray_vld,
   input  logic [3:0]       i_gray,
   input  logic             i_clr,
   output logic [3:0]       o_bin,
   output logic [POS_W-1:0] o_pos,
   output logic [1:0]       o_dir,
   output logic             o_step,
   output logic             o_err,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic             o_locked
);

   state_t           state_q, state_d;
   logic [3:0]       bin_q, bin_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [1:0]       dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [3:0]       bin_new;
   logic [3:0]       diff;
   logic             is_up;
   logic             is_dn;
   logic             is_same;

   gray2bin4 u_gray2bin4 (
      .i_gray (i_gray),
      .o_bin  (bin_new)
   );

   // The held o_bin value doubles as the reference sample; wrap-around of
   // the 4-bit subtraction turns 15->0 into +1 and 0->15 into -1.
   assign diff    = bin_new - bin_q;
   assign is_same = (diff == 4'd0);
   assign is_up   = (diff == 4'd1);
   assign is_dn   = (diff == 4'd15);

   // Next-state and next-output computation; clear beats a concurrent sample.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      step_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (i_clr) begin
         state_d   = UNLOCKED;
         bin_d     = 4'd0;
         pos_d     = '0;
         dir_d     = DIR_NONE;
         err_cnt_d = '0;
      end else if (i_gray_vld) begin
         bin_d = bin_new;
         if (state_q == UNLOCKED) begin
            state_d = LOCKED;
         end else if (is_same) begin
            dir_d = DIR_NONE;
         end else if (is_up) begin
            pos_d  = pos_q + POS_W'(1);
            dir_d  = DIR_UP;
            step_d = 1'b1;
         end else if (is_dn) begin
            pos_d  = pos_q - POS_W'(1);
            dir_d  = DIR_DN;
            step_d = 1'b1;
         end else begin
            dir_d = DIR_NONE;
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
               err_cnt_d = err_cnt_q + ERR_W'(1);
            end
         end
      end
   end

   // Single registered update of all tracking state with async reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= UNLOCKED;
         bin_q     <= 4'd0;
         pos_q     <= '0;
         dir_q     <= DIR_NONE;
         step_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_bin     = bin_q;
   assign o_pos     = pos_q;
   assign o_dir     = dir_q;
   assign o_step    = step_q;
   assign o_err     = err_q;
   assign o_err_cnt = err_cnt_q;
   assign o_locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_gray_pos_tracker.sv
// tb/tb_gray_pos_tracker.sv - randomized self-checking bench for gray_pos_tracker
module tb_gray_pos_tracker;

   localparam int POS_W = 8;
   localparam int ERR_W = 8;
   localparam longint POS_MOD = 64'd1 << POS_W;
   localparam longint CNT_MAX = (64'd1 << ERR_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             gray_vld;
   logic [3:0]       gray;
   logic             clr;
   logic [3:0]       bin;
   logic [POS_W-1:0] pos;
   logic [1:0]       dir;
   logic             step;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             locked;

   int n_tests;
   int n_fail;
   bit chk_en;

   // reference model state
   bit     m_locked;
   int     m_ref;
   longint m_pos;
   int     m_dir;
   bit     m_step;
   bit     m_err;
   longint m_cnt;

   gray_pos_tracker #(.POS_W(POS_W), .ERR_W(ERR_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_gray_vld (gray_vld),
      .i_gray     (gray),
      .i_clr      (clr),
      .o_bin      (bin),
      .o_pos      (pos),
      .o_dir      (dir),
      .o_step     (step),
      .o_err      (err),
      .o_err_cnt  (err_cnt),
      .o_locked   (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] enc(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   // decode by searching the code table rather than by XOR chain
   function automatic int dec(input logic [3:0] g);
      for (int b = 0; b < 16; b++) begin
         if (enc(b) == g) return b;
      end
      return 0;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_ref = 0; m_pos = 0; m_dir = 0;
      m_step = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic model_update(input bit c, input bit v, input logic [3:0] g);
      int nb;
      int d;
      m_step = 0;
      m_err  = 0;
      if (c) begin
         model_reset();
      end else if (v) begin
         nb = dec(g);
         if (!m_locked) begin
            m_locked = 1;
         end else begin
            d = (nb - m_ref + 16) % 16;
            if (d == 0) begin
               m_dir = 0;
            end else if (d == 1) begin
               m_pos = (m_pos + 1) % POS_MOD; m_dir = 1; m_step = 1;
            end else if (d == 15) begin
               m_pos = (m_pos - 1 + POS_MOD) % POS_MOD; m_dir = 2; m_step = 1;
            end else begin
               m_err = 1; m_dir = 0;
               if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
         end
         m_ref = nb;
      end
   endtask

   // one clock with given inputs; model tracks the edge, inputs change 1 after it
   task automatic cycle(input bit c, input bit v, input logic [3:0] g);
      clr = c; gray_vld = v; gray = g;
      @(posedge clk);
      model_update(c, v, g);
      #1;
   endtask

   task automatic sample_bin(input int b);
      cycle(1'b0, 1'b1, enc(b));
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("bin", bin, m_ref);
         check("pos", pos, m_pos);
         check("dir", dir, m_dir);
         check("step", step, m_step);
         check("err", err, m_err);
         check("err_cnt", err_cnt, m_cnt);
         check("locked", locked, m_locked);
         check("step_err_excl", step & err, 0);
      end
   end

   initial begin
      int cur;
      n_tests = 0; n_fail = 0; chk_en = 0;
      clr = 0; gray_vld = 0; gray = 4'd0;
      model_reset();
      rst_n = 1'b0;
      #12;
      check("rst_pos", pos, 0);
      check("rst_locked", locked, 0);
      check("rst_cnt", err_cnt, 0);
      check("rst_dir", dir, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1;

      // basic lock then up step
      cycle(0, 1, 4'b0000);
      check("lit_lock_locked", locked, 1);
      check("lit_lock_pos", pos, 0);
      check("lit_lock_step", step, 0);
      cycle(0, 1, 4'b0001);
      check("lit_up_pos", pos, 1);
      check("lit_up_dir", dir, 2'b01);
      check("lit_up_step", step, 1);
      cycle(0, 0, 4'b0000);
      check("lit_step_pulse", step, 0);
      check("lit_dir_held", dir, 2'b01);

      // wrap 15 -> 0 and back
      cycle(1, 0, 4'b0000);
      cycle(0, 1, 4'b1000);
      cycle(0, 1, 4'b0000);
      check("lit_wrap_up_pos", pos, 1);
      check("lit_wrap_up_step", step, 1);
      cycle(0, 1, 4'b1000);
      check("lit_wrap_dn_pos", pos, 0);
      check("lit_wrap_dn_dir", dir, 2'b10);

      // illegal jump then resync
      cycle(1, 0, 4'b0000);
      cycle(0, 1, 4'b0000);
      cycle(0, 1, 4'b0011);
      check("lit_jump_err", err, 1);
      check("lit_jump_cnt", err_cnt, 1);
      check("lit_jump_pos", pos, 0);
      check("lit_jump_bin", bin, 2);
      cycle(0, 1, 4'b0010);
      check("lit_resync_pos", pos, 1);

      // 128 ups -> 0x80, then saturate the error counter
      cycle(1, 0, 4'b0000);
      sample_bin(0);
      for (int i = 1; i <= 128; i++) sample_bin(i % 16);
      check("lit_pos_wrap", pos, 8'h80);
      for (int i = 0; i < 300; i++) sample_bin((i % 2 == 0) ? 8 : 0);
      check("lit_cnt_sat", err_cnt, 8'hFF);
      check("lit_cnt_sat_pos", pos, 8'h80);

      // clear with concurrent sample
      cycle(1, 0, 4'b0000);
      sample_bin(0);
      for (int i = 1; i <= 5; i++) sample_bin(i);
      check("lit_pos5", pos, 5);
      cycle(1, 1, enc(6));
      check("lit_clr_pos", pos, 0);
      check("lit_clr_locked", locked, 0);
      sample_bin(9);
      check("lit_relock_step", step, 0);
      check("lit_relock_locked", locked, 1);

      // randomized walk
      cur = 9;
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 3) cur = (cur + 1) % 16;
         else if (r <= 6) cur = (cur + 15) % 16;
         else if (r >= 8) cur = $urandom_range(0, 15);
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), enc(cur));
      end

      // async reset between edges
      sample_bin(cur);
      sample_bin((cur + 1) % 16);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("lit_arst_pos", pos, 0);
      check("lit_arst_locked", locked, 0);
      check("lit_arst_bin", bin, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sample_bin(3);
      check("lit_arst_relock_step", step, 0);
      sample_bin(4);
      check("lit_arst_after_pos", pos, 1);
      for (int i = 0; i < 200; i++) begin
         cur = (($urandom_range(0, 1) == 1) ? cur + 1 : cur + 15) % 16;
         cycle(0, ($urandom_range(0, 1) == 1), enc(cur));
      end

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_pos_tracker.md
GRAY_POS_TRACKER -- requirements
Module: gray_pos_tracker

Interface
REQ-001 Parameter POS_W, default 8: width of the signed position accumulator (legal range 4..32).
REQ-002 Parameter ERR_W, default 8: width of the saturating error counter (legal range 1..16).
REQ-003 i_clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_gray_vld  input  1  sample strobe; i_gray is sampled when this is high.
REQ-006 i_gray  input  4  4-bit reflected Gray code sample from the upstream registered binary-to-Gray encoder.
REQ-007 i_clr  input  1  synchronous clear of the tracking state.
REQ-008 o_bin  output  4  binary decode of the last accepted sample.
REQ-009 o_pos  output  POS_W  two's-complement accumulated position.
REQ-010 o_dir  output  2  last movement: 00 none, 01 up, 10 down; 11 is never driven.
REQ-011 o_step  output  1  one-cycle pulse when o_pos changes.
REQ-012 o_err  output  1  one-cycle pulse on an illegal transition.
REQ-013 o_err_cnt  output  ERR_W  saturating count of illegal transitions.
REQ-014 o_locked  output  1  high while a reference sample is held.

Function
REQ-015 Decode: bin[3] = g[3]; bin[i] = bin[i+1] XOR g[i] for i = 2..0.
REQ-016 All outputs SHALL be registered, with 1-cycle latency: an i_gray_vld sample at edge N is reflected at edge N+1.
REQ-017 FSM states SHALL be UNLOCKED and LOCKED; o_locked = (state == LOCKED).
REQ-018 UNLOCKED with i_gray_vld: store the sample as reference, update o_bin, go to LOCKED; o_pos, o_step and o_err SHALL be unaffected (o_step = o_err = 0).
REQ-019 LOCKED with i_gray_vld: d = (bin_new - bin_ref) mod 16; the reference and o_bin SHALL always update to bin_new.
REQ-020 d = 0: o_dir = 00, no step, o_pos held.
REQ-021 d = 1: o_pos + 1, o_dir = 01, o_step = 1.
REQ-022 d = 15: o_pos - 1, o_dir = 10, o_step = 1.
REQ-023 d in 2..14 (more than one Gray bit changed):
  - o_err = 1, o_err_cnt + 1, o_dir = 00, o_pos held;
  - the new sample becomes the reference (resync) and the state stays LOCKED.
REQ-024 Code wrap 15->0 SHALL count +1 and 0->15 SHALL count -1.
REQ-025 o_pos SHALL wrap modulo 2^POS_W (for example 0x7F + 1 = 0x80, with no saturation).
REQ-026 o_err_cnt SHALL saturate at all-ones and hold.
REQ-027 i_gray_vld low: all state held; o_step and o_err SHALL be 0; o_dir held.
REQ-028 i_clr high has priority over i_gray_vld in the same cycle:
  - o_pos = 0, o_err_cnt = 0, o_dir = 00, o_bin = 0, o_step = o_err = 0;
  - state goes to UNLOCKED and the concurrent sample is discarded.
REQ-029 o_step and o_err SHALL never be high in the same cycle.

Reset
REQ-030 While i_rst_n is low, the block SHALL be asynchronously forced to: state UNLOCKED, o_bin = 0, o_pos = 0, o_dir = 00, o_step = 0, o_err = 0, o_err_cnt = 0, o_locked = 0.
REQ-031 Reset asserted mid-operation SHALL discard the reference; the first valid sample after release SHALL relock without a step.
REQ-032 Deassertion SHALL be taken synchronously to i_clk upstream of this block; no internal synchronizer is required.

Structure
REQ-033 The shared package SHALL hold:
  - the FSM state encoding (UNLOCKED = 0, LOCKED = 1);
  - the o_dir constants DIR_NONE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10.
REQ-034 The Gray-to-binary decode SHALL be a combinational sub-module gray2bin4 (4-bit in, 4-bit out), instantiated once on i_gray.
REQ-035 The modular difference and its classification SHALL be combinational and feed a single registered update process.

Verification
REQ-036 Reset, then i_gray = 0000 with vld, then 0001 -> o_locked = 1 with o_pos = 0 after the first sample; o_pos = 1, o_dir = 01 and a one-cycle o_step after the second.
REQ-037 Lock at Gray 1000 (bin 15), then Gray 0000 -> o_pos +1, o_step = 1; reverse the sequence -> o_pos -1, o_dir = 10.
REQ-038 Lock at Gray 0000, then Gray 0011 (bin 2) -> o_err pulse, o_err_cnt = 1, o_pos unchanged, o_bin = 2; then Gray 0010 (bin 3) -> o_pos +1.
REQ-039 POS_W = 8: 128 consecutive up steps from 0 -> o_pos = 0x80; 300 illegal jumps with ERR_W = 8 -> o_err_cnt = 0xFF.
REQ-040 i_clr and i_gray_vld high together with o_pos = 5 -> o_pos = 0, o_locked = 0; the next sample relocks with no step.
REQ-041 i_rst_n pulsed low between edges mid-stream -> outputs go to reset values immediately, before the next clock edge.
